// File: rtl/uart_tx_word_arbiter_if.sv
// Handshake bundle between the message sources, the word arbiter and the byte serializer.
// The master modport is the arbiter side; the slave modport is the sources/serializer side.
interface uart_tx_word_arbiter_if #(
  parameter int NUM_REQ       = 4,
  parameter int W_IN          = 16,
  parameter int BITS_PER_WORD = 8
);
  localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]      s_valid;
  logic [NUM_REQ-1:0]      s_ready;
  logic [NUM_REQ*W_IN-1:0] s_data;
  logic                    w_valid;
  logic                    w_ready;
  logic [BITS_PER_WORD-1:0] w_data;
  logic                    w_last;
  logic [GID_W-1:0]        grant_id;
  logic                    busy;

  modport master (
    input  s_valid, s_data, w_ready,
    output s_ready, w_valid, w_data, w_last, grant_id, busy
  );

  modport slave (
    output s_valid, s_data, w_ready,
    input  s_ready, w_valid, w_data, w_last, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_word_arbiter.sv
// Round-robin arbiter sharing one word-wide UART TX serializer among NUM_REQ message sources.
// A grant covers a whole message, sent word 0 first, followed by GAP_CYCLES idle clocks.
module uart_tx_word_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int W_IN          = 16,
  parameter int BITS_PER_WORD = 8,
  parameter int GAP_CYCLES    = 4
) (
  input logic                   clk,
  input logic                   rstn,
  uart_tx_word_arbiter_if.master bus
);
  localparam int NUM_WORDS = W_IN / BITS_PER_WORD;
  localparam int GID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WC_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int GC_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned NREQ_U = NUM_REQ;

  localparam logic [WC_W-1:0]  LAST_WORD = WC_W'(NUM_WORDS - 1);
  localparam logic [GC_W-1:0]  LAST_GAP  = GC_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GID_W-1:0] PTR_RESET = GID_W'(NUM_REQ - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  if ((W_IN % BITS_PER_WORD) != 0 || W_IN < BITS_PER_WORD) begin : g_bad_width
    $error("uart_tx_word_arbiter: W_IN must be a non-zero multiple of BITS_PER_WORD");
  end

  logic [1:0]                                 state;
  logic [GID_W-1:0]                           ptr;
  logic [GID_W-1:0]                           grant_q;
  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]    buffer;
  logic [WC_W-1:0]                            word_cnt;
  logic [GC_W-1:0]                            gap_cnt;

  logic [NUM_REQ-1:0][W_IN-1:0]               src_data;
  logic                                       req_any;
  logic [GID_W-1:0]                           pick;
  logic [GID_W-1:0]                           cand;
  int unsigned                                cand_full;
  logic [NUM_REQ-1:0]                         ready;

  assign src_data = bus.s_data;

  // Search starts one past the last grant, so the previous owner has lowest priority.
  always_comb begin
    req_any   = 1'b0;
    pick      = '0;
    cand      = '0;
    cand_full = 0;
    for (int unsigned i = 1; i <= NREQ_U; i++) begin
      cand_full = (32'(ptr) + i) % NREQ_U;
      cand      = GID_W'(cand_full);
      if (!req_any && bus.s_valid[cand]) begin
        req_any = 1'b1;
        pick    = cand;
      end
    end
  end

  always_comb begin
    ready = '0;
    if (rstn && state == IDLE && req_any) begin
      ready[pick] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      ptr      <= PTR_RESET;
      grant_q  <= '0;
      buffer   <= '0;
      word_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            buffer   <= src_data[pick];
            grant_q  <= pick;
            ptr      <= pick;
            word_cnt <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (bus.w_ready) begin
            if (word_cnt == LAST_WORD) begin
              gap_cnt <= '0;
              state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_cnt == LAST_GAP) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_ready  = ready;
  assign bus.w_valid  = (state == SEND);
  assign bus.w_data   = (state == SEND) ? buffer[word_cnt] : '0;
  assign bus.w_last   = (state == SEND) && (word_cnt == LAST_WORD);
  assign bus.grant_id = grant_q;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_word_arbiter.sv
// Bench for uart_tx_word_arbiter: directed message table, hand-written corner sequences,
// and a randomized run checked against a queue-based round-robin message model.
module tb_uart_tx_word_arbiter;
  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  uart_tx_word_arbiter_if #(.NUM_REQ(4), .W_IN(16), .BITS_PER_WORD(8)) bus ();

  uart_tx_word_arbiter #(
    .NUM_REQ(4), .W_IN(16), .BITS_PER_WORD(8), .GAP_CYCLES(4)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int          src;
    logic [15:0] data;
    int          stall;
    logic [7:0]  w0;
    logic [7:0]  w1;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  // Waits for the grant, then consumes both words; returns in the first cycle after the last word.
  task automatic run_msg(input int src, input logic [7:0] w0, input logic [7:0] w1,
                         input int stall, input bit drop);
    int t;
    logic [7:0] exp_w;
    t = 0;
    bus.w_ready = 1'b1;
    #1;
    while (bus.s_ready == '0 && t < 40) begin
      @(posedge clk); #2;
      t++;
    end
    check("grant_ready", 64'(bus.s_ready), 64'd1 << src);
    @(posedge clk); #1;
    check("ready_one_cycle", 64'(bus.s_ready), 64'd0);
    if (drop) bus.s_valid[src] = 1'b0;
    for (int w = 0; w < 2; w++) begin
      exp_w = (w == 0) ? w0 : w1;
      if (w == 0 && stall > 0) begin
        bus.w_ready = 1'b0;
        for (int c = 0; c < stall; c++) begin
          #1;
          check("stall_valid", 64'(bus.w_valid), 64'd1);
          check("stall_data", 64'(bus.w_data), 64'(exp_w));
          @(posedge clk); #1;
        end
        bus.w_ready = 1'b1;
      end
      #1;
      check("word_valid", 64'(bus.w_valid), 64'd1);
      check("word_data", 64'(bus.w_data), 64'(exp_w));
      check("word_last", 64'(bus.w_last), (w == 1) ? 64'd1 : 64'd0);
      check("grant_id", 64'(bus.grant_id), 64'(src));
      check("busy_send", 64'(bus.busy), 64'd1);
      @(posedge clk); #1;
    end
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  logic [15:0] q[4][$];
  logic [15:0] inflight;
  logic [3:0]  sv;
  int          last_g, exp_g, widx, last_end, done_msgs, pending, r;
  bit          have;

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    bus.s_valid = 4'hF;
    bus.s_data  = '0;
    bus.w_ready = 1'b0;

    vecs[0] = '{1, 16'hA55A, 0,  8'h5A, 8'hA5};
    vecs[1] = '{0, 16'h1234, 10, 8'h34, 8'h12};
    vecs[2] = '{3, 16'hFF00, 2,  8'h00, 8'hFF};
    vecs[3] = '{2, 16'h0001, 0,  8'h01, 8'h00};
    vecs[4] = '{1, 16'hBEEF, 1,  8'hEF, 8'hBE};

    // reset state, with every source requesting while rstn is low
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", 64'(bus.s_ready), 64'd0);
    check("rst_w_valid", 64'(bus.w_valid), 64'd0);
    check("rst_w_data", 64'(bus.w_data), 64'd0);
    check("rst_w_last", 64'(bus.w_last), 64'd0);
    check("rst_grant_id", 64'(bus.grant_id), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    rstn = 1'b1;
    bus.s_valid = '0;
    @(posedge clk); #1;
    check("idle_no_req", 64'(bus.s_ready), 64'd0);

    // directed single-source messages, including serializer stalls
    for (int v = 0; v < 5; v++) begin
      bus.s_data[vecs[v].src*16 +: 16] = vecs[v].data;
      bus.s_valid = 4'(1 << vecs[v].src);
      run_msg(vecs[v].src, vecs[v].w0, vecs[v].w1, vecs[v].stall, 1'b1);
    end

    // inter-message gap: last word accepted at edge E, now in cycle E+1
    bus.s_data[15:0] = 16'h6C39;
    bus.s_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("gap_busy", 64'(bus.busy), 64'd1);
      check("gap_no_ready", 64'(bus.s_ready), 64'd0);
      check("gap_no_valid", 64'(bus.w_valid), 64'd0);
      @(posedge clk); #1;
    end
    #1;
    check("gap_end_ready", 64'(bus.s_ready), 64'd1);
    run_msg(0, 8'h39, 8'h6C, 0, 1'b1);

    // all sources requesting: grants rotate 0,1,2,3,0
    bus.s_valid = '0;
    do_reset();
    for (int i = 0; i < 4; i++) bus.s_data[i*16 +: 16] = {8'hA0 + 8'(i), 8'h50 + 8'(i)};
    bus.s_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      run_msg(k % 4, 8'h50 + 8'(k % 4), 8'hA0 + 8'(k % 4), 0, 1'b0);
    end
    bus.s_valid = '0;

    // reset mid-message: src2 owns the line, word 0 accepted, then a one-cycle reset
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    bus.s_data[47:32] = 16'h7E81;
    bus.s_valid = 4'b0100;
    bus.w_ready = 1'b1;
    #1;
    check("mid_grant2", 64'(bus.s_ready), 64'd4);
    @(posedge clk); #1;
    bus.s_valid = '0;
    check("mid_word0", 64'(bus.w_data), 64'h81);
    @(posedge clk); #1;
    check("mid_word1", 64'(bus.w_data), 64'h7E);
    rstn = 1'b0;
    bus.s_data[15:0]  = 16'h2D4B;
    bus.s_data[63:48] = 16'h9999;
    bus.s_valid = 4'b1001;
    #1;
    check("mid_rst_ready", 64'(bus.s_ready), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
    check("mid_rst_w_valid", 64'(bus.w_valid), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_grant_id", 64'(bus.grant_id), 64'd0);
    check("mid_rst_ptr", 64'(bus.s_ready), 64'd1);
    run_msg(0, 8'h4B, 8'h2D, 0, 1'b1);
    bus.s_valid = '0;

    // randomized sources and serializer backpressure against a queue model
    do_reset();
    last_g = 3;
    last_end = -1;
    have = 1'b0;
    widx = 0;
    done_msgs = 0;
    inflight = '0;
    for (int c = 0; c < 1600; c++) begin
      if (c < 1000 && $urandom_range(5) == 0) begin
        r = $urandom_range(3);
        if (q[r].size() < 3) q[r].push_back(16'($urandom));
      end
      for (int i = 0; i < 4; i++) begin
        sv[i] = (q[i].size() > 0) && ($urandom_range(3) != 0);
        if (q[i].size() > 0) bus.s_data[i*16 +: 16] = q[i][0];
      end
      bus.s_valid = sv;
      bus.w_ready = ($urandom_range(2) != 0);
      #1;
      if (bus.s_ready != '0) begin
        exp_g = rr_pick(sv, last_g);
        check("rnd_grant", 64'(bus.s_ready), (exp_g >= 0) ? (64'd1 << exp_g) : 64'd0);
        if (last_end >= 0) check("rnd_gap", 64'(c - last_end >= 5), 64'd1);
        if (exp_g >= 0) begin
          inflight = q[exp_g].pop_front();
          last_g = exp_g;
          have = 1'b1;
          widx = 0;
        end
      end
      if (bus.w_valid && bus.w_ready) begin
        if (!have) begin
          check("rnd_spurious_word", 64'd1, 64'd0);
        end else begin
          check("rnd_word", 64'(bus.w_data), 64'(inflight[widx*8 +: 8]));
          check("rnd_last", 64'(bus.w_last), (widx == 1) ? 64'd1 : 64'd0);
          check("rnd_grant_id", 64'(bus.grant_id), 64'(last_g));
          if (widx == 1) begin
            have = 1'b0;
            last_end = c;
            done_msgs++;
          end else begin
            widx++;
          end
        end
      end
      @(posedge clk); #1;
    end
    pending = 0;
    for (int i = 0; i < 4; i++) pending += q[i].size();
    if (have) pending++;
    check("rnd_drain", 64'(pending), 64'd0);
    check("rnd_msg_count", 64'(done_msgs > 50), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
